msx_key_matrix: RTL and testbench

- Converts MiSTer PS/2 key events into the MSX keyboard matrix that the PPI samples on port B.
- Row select comes from PPI port C[3:0]; the selected row's data is returned active-low.
- Key-code-to-matrix mapping is a 512-entry table held in internal block RAM.
- The slot subsystem reloads the table at runtime over a simple write port.

---
 rtl/msx_key_matrix.sv | 165 ++++++++++++++++
 tb/tb_msx_key_matrix.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/msx_key_matrix.sv
// MSX keyboard matrix fed by MiSTer PS/2 key events.
// A 512-entry RAM maps {extended, scan code} to {valid, row, column}; a small
// FSM looks each event up and sets or clears one matrix bit. The PPI reads the
// selected row active-low through a registered output.

// One matrix row: eight key bits, 1 = released.
module msx_key_row (
  input  logic       clk21m,
  input  logic       reset,
  input  logic       clr,
  input  logic       wr,
  input  logic [2:0] col,
  input  logic       val,
  output logic [7:0] bits
);

  // Release-all wins over a single-key update landing in the same cycle.
  always_ff @(posedge clk21m or posedge reset) begin
    if (reset)    bits      <= 8'hFF;
    else if (clr) bits      <= 8'hFF;
    else if (wr)  bits[col] <= val;
  end

endmodule

module msx_key_matrix #(
  parameter int ROWS = 11
) (
  input  logic        clk21m,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic [3:0]  kb_row,
  output logic [7:0]  kb_data,
  input  logic [8:0]  kbd_addr,
  input  logic [7:0]  kbd_din,
  input  logic        kbd_we,
  input  logic        kbd_request
);

  typedef enum logic [1:0] {IDLE, READ, APPLY} state_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] row;
    logic [2:0] col;
  } entry_t;

  typedef struct packed {
    logic       press;
    logic       ext;
    logic [7:0] code;
  } event_t;

  logic                 toggle_q;
  logic                 new_event;
  logic                 pending;
  event_t               pend_ev;
  logic                 req_q;
  logic                 release_all;
  state_t               state, state_nxt;
  logic                 accept, apply;
  logic [8:0]           lookup_addr;
  logic                 press_q;
  logic [7:0]           ram [512];
  logic [7:0]           rdata;
  entry_t               entry;
  logic [ROWS-1:0]      row_wr;
  logic [ROWS-1:0][7:0] matrix;

  assign new_event   = ps2_key[10] ^ toggle_q;
  assign release_all = kbd_request & ~req_q;
  assign entry       = entry_t'(rdata);

  // Toggle tracker has no async reset on purpose: it keeps sampling while
  // reset is held, so it already matches ps2_key[10] when reset releases
  // and a stale toggle is never seen as a new event.
  always_ff @(posedge clk21m) toggle_q <= ps2_key[10];

  // Pending event register; a toggle arriving as the FSM accepts wins.
  always_ff @(posedge clk21m or posedge reset) begin
    if (reset) begin
      pending <= 1'b0;
      pend_ev <= '0;
    end else if (new_event) begin
      pending <= 1'b1;
      pend_ev <= event_t'(ps2_key[9:0]);
    end else if (accept) begin
      pending <= 1'b0;
    end
  end

  // kbd_request edge detect for the release-all on load start.
  always_ff @(posedge clk21m or posedge reset) begin
    if (reset) req_q <= 1'b0;
    else       req_q <= kbd_request;
  end

  // FSM state register.
  always_ff @(posedge clk21m or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: lookups start only with the port free and no load running;
  // READ holds while a write owns the RAM port so APPLY sees fresh data.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    apply     = 1'b0;
    case (state)
      IDLE: begin
        if (pending && !kbd_request && !kbd_we) begin
          accept    = 1'b1;
          state_nxt = READ;
        end
      end
      READ:  if (!kbd_we) state_nxt = APPLY;
      APPLY: begin
        apply     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the accepted event so new toggles can refill pending meanwhile.
  always_ff @(posedge clk21m or posedge reset) begin
    if (reset) begin
      lookup_addr <= '0;
      press_q     <= 1'b0;
    end else if (accept) begin
      lookup_addr <= {pend_ev.ext, pend_ev.code};
      press_q     <= pend_ev.press;
    end
  end

  // Single-port table RAM: a write takes the port, otherwise read lookup_addr.
  always_ff @(posedge clk21m) begin
    if (kbd_we) ram[kbd_addr] <= kbd_din;
    else        rdata         <= ram[lookup_addr];
  end

  // Rows beyond ROWS never match, so out-of-range entries fall away here.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    assign row_wr[r] = apply && entry.valid && (entry.row == 4'(r));

    msx_key_row u_row (
      .clk21m (clk21m),
      .reset  (reset),
      .clr    (release_all),
      .wr     (row_wr[r]),
      .col    (entry.col),
      .val    (~press_q),
      .bits   (matrix[r])
    );
  end

  // Registered row readout; unimplemented rows read as all released.
  always_ff @(posedge clk21m or posedge reset) begin
    if (reset)                    kb_data <= 8'hFF;
    else if (int'(kb_row) < ROWS) kb_data <= matrix[kb_row];
    else                          kb_data <= 8'hFF;
  end

endmodule

// File: tb/tb_msx_key_matrix.sv
// Bench for msx_key_matrix: directed scenarios plus randomized key events and
// table writes, checked against an event-level model of the key matrix.
module tb_msx_key_matrix;

  localparam int ROWS = 11;

  logic        clk21m = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] ps2_key = '0;
  logic [3:0]  kb_row = '0;
  logic [7:0]  kb_data;
  logic [8:0]  kbd_addr = '0;
  logic [7:0]  kbd_din = '0;
  logic        kbd_we = 1'b0;
  logic        kbd_request = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  // Model: table image and keys held down (1 = down) per row.
  logic [7:0] tbl  [512];
  logic [7:0] down [16];
  logic [8:0] codes [8] = '{9'h01C, 9'h01B, 9'h175, 9'h000,
                            9'h02A, 9'h033, 9'h14A, 9'h0F0};
  logic [7:0] init_val [8] = '{8'hB6, 8'hA9, 8'hC7, 8'h00,
                               8'hDA, 8'h88, 8'hD5, 8'h80};
  int   k, j, nw;
  logic p;

  always #5 clk21m = ~clk21m;

  msx_key_matrix #(.ROWS(ROWS)) dut (
    .clk21m      (clk21m),
    .reset       (reset),
    .ps2_key     (ps2_key),
    .kb_row      (kb_row),
    .kb_data     (kb_data),
    .kbd_addr    (kbd_addr),
    .kbd_din     (kbd_din),
    .kbd_we      (kbd_we),
    .kbd_request (kbd_request)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk21m);
    #1;
  endtask

  task automatic wr(input logic [8:0] a, input logic [7:0] d);
    kbd_addr = a; kbd_din = d; kbd_we = 1'b1;
    tick(1);
    kbd_we = 1'b0;
    tbl[a] = d;
  endtask

  task automatic key(input logic press, input logic [8:0] a);
    ps2_key = {~ps2_key[10], press, a};
  endtask

  function automatic void model_apply(input logic press, input logic [8:0] a);
    logic [7:0] e;
    e = tbl[a];
    if (e[7] && int'(e[6:3]) < ROWS) down[e[6:3]][e[2:0]] = press;
  endfunction

  function automatic void model_release();
    for (int i = 0; i < 16; i++) down[i] = '0;
  endfunction

  task automatic expect_row(input string tag, input int r);
    kb_row = 4'(r);
    tick(1);
    chk(tag, kb_data, (r < ROWS) ? ~down[r] : 8'hFF);
  endtask

  task automatic check_all(input string tag);
    for (int r = 0; r < 16; r++) expect_row(tag, r);
  endtask

  task automatic press_wait(input logic press, input logic [8:0] a);
    key(press, a);
    tick(5);
    model_apply(press, a);
  endtask

  initial begin
    model_release();
    tick(3);
    chk("reset_kb_data", kb_data, 8'hFF);
    reset = 1'b0;
    tick(1);

    // Initial table load under kbd_request.
    kbd_request = 1'b1;
    tick(1);
    for (int i = 0; i < 8; i++) wr(codes[i], init_val[i]);
    kbd_request = 1'b0;
    tick(2);
    check_all("reset_matrix");

    // 1: A press / release.
    kb_row = 4'd6;
    press_wait(1'b1, 9'h01C);
    chk("a_press", kb_data, 8'hBF);
    press_wait(1'b0, 9'h01C);
    chk("a_release", kb_data, 8'hFF);

    // 2: extended key.
    kb_row = 4'd8;
    press_wait(1'b1, 9'h175);
    chk("ext_press", kb_data, 8'h7F);
    expect_row("ext_row0", 0);
    expect_row("ext_row8", 8);

    // 3: invalid and out-of-range entries leave the matrix alone.
    press_wait(1'b1, 9'h000);
    press_wait(1'b1, 9'h02A);
    tick(2);
    check_all("invalid");

    // 4: back-to-back toggles while busy: only the newest survives.
    key(1'b1, 9'h000); tick(1);
    key(1'b1, 9'h01C); tick(1);
    key(1'b1, 9'h01B); tick(8);
    model_apply(1'b1, 9'h01B);
    expect_row("coalesce_r6", 6);
    expect_row("coalesce_r5", 5);
    press_wait(1'b0, 9'h01B);
    press_wait(1'b1, 9'h01C);
    tick(5);
    press_wait(1'b1, 9'h01B);
    tick(2);
    expect_row("both_r6", 6);
    expect_row("both_r5", 5);

    // 5: table reload releases keys and holds events until it ends.
    kb_row = 4'd6;
    tick(1);
    kbd_request = 1'b1;
    tick(2);
    model_release();
    chk("req_release", kb_data, 8'hFF);
    wr(9'h01C, 8'hA0);
    key(1'b1, 9'h01C);
    tick(8);
    check_all("req_hold");
    kbd_request = 1'b0;
    tick(5);
    model_apply(1'b1, 9'h01C);
    expect_row("req_resume_r4", 4);
    expect_row("req_resume_r6", 6);

    // 6: reset with the FSM in READ and a key held.
    kb_row = 4'd4;
    key(1'b1, 9'h033);
    tick(2);
    reset = 1'b1;
    tick(1);
    chk("rst_mid", kb_data, 8'hFF);
    tick(2);
    reset = 1'b0;
    model_release();
    tick(8);
    check_all("no_replay");

    // Randomized events with table rewrites and writes racing lookups.
    for (int it = 0; it < 30; it++) begin
      k = $urandom_range(0, 7);
      p = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) wr(codes[$urandom_range(0, 7)], 8'($urandom));
      key(p, codes[k]);
      nw = $urandom_range(0, 4);
      if (nw > 0) begin
        j = (k + 1 + $urandom_range(0, 6)) % 8;
        kbd_addr = codes[j];
        kbd_we = 1'b1;
        for (int c = 0; c < nw; c++) begin
          kbd_din = 8'($urandom);
          tbl[codes[j]] = kbd_din;
          tick(1);
        end
        kbd_we = 1'b0;
      end
      tick(6);
      model_apply(p, codes[k]);
      for (int c = 0; c < 3; c++) expect_row("rnd", $urandom_range(0, 15));
    end
    check_all("rnd_final");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
